// File: rtl/mcmc_proposal_sequencer.sv
// Proposal sequencer: drives the RNG stage draw by draw and assembles a proposal
// vector (resample-all or resample-one-random-variable), then holds it for a valid/ready consumer.
module mcmc_proposal_sequencer #(
    parameter int NUM_VARS = 4,
    parameter int VAL_W    = 8
) (
    input  logic                      in_clock,
    input  logic                      in_reset_n,
    input  logic                      in_start,
    input  logic                      in_mode,
    input  logic [NUM_VARS*VAL_W-1:0] in_lower,
    input  logic [NUM_VARS*VAL_W-1:0] in_upper,
    input  logic [NUM_VARS*VAL_W-1:0] in_current,
    output logic                      out_gen_enable,
    output logic [VAL_W-1:0]          out_gen_min,
    output logic [VAL_W-1:0]          out_gen_max,
    input  logic [VAL_W-1:0]          in_gen_random,
    output logic [NUM_VARS*VAL_W-1:0] out_proposal,
    output logic                      out_valid,
    input  logic                      in_ready,
    output logic                      out_busy,
    output logic                      out_error
);
    localparam int KW = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;
    localparam logic signed [VAL_W:0] LIM = (VAL_W+1)'(126);

    typedef enum logic [2:0] {
        S_IDLE, S_IDX_REQ, S_IDX_CAP, S_VAL_REQ, S_VAL_CAP, S_HOLD
    } state_t;

    state_t                 r_state, w_state_next;
    logic                   r_mode;
    logic [KW-1:0]          r_k;
    logic                   r_error;
    logic [VAL_W-1:0]       r_min_hold, r_max_hold;
    logic [VAL_W-1:0]       r_lower [NUM_VARS];
    logic [VAL_W-1:0]       r_upper [NUM_VARS];
    logic [VAL_W-1:0]       r_prop  [NUM_VARS];

    logic                   w_accept;
    logic [VAL_W-1:0]       w_k_lo, w_k_hi;
    logic signed [VAL_W:0]  w_lo9, w_hi9, w_span9;
    logic                   w_legal;
    logic                   w_idx_ok;
    logic [KW-1:0]          w_idx;
    logic                   w_last_var;

    assign w_accept   = (r_state == S_IDLE) && in_start;
    assign w_k_lo     = r_lower[r_k];
    assign w_k_hi     = r_upper[r_k];
    // Range legality uses one extra bit so the span cannot wrap.
    assign w_lo9      = $signed({w_k_lo[VAL_W-1], w_k_lo});
    assign w_hi9      = $signed({w_k_hi[VAL_W-1], w_k_hi});
    assign w_span9    = w_hi9 - w_lo9;
    assign w_legal    = (w_lo9 <= w_hi9) && (w_hi9 <= LIM) && (w_span9 <= LIM);
    assign w_idx_ok   = !in_gen_random[VAL_W-1] && (in_gen_random < VAL_W'(NUM_VARS));
    assign w_idx      = w_idx_ok ? in_gen_random[KW-1:0] : '0;
    assign w_last_var = (r_k == KW'(NUM_VARS-1));

    always_ff @(posedge in_clock) begin
        if (!in_reset_n) r_state <= S_IDLE;
        else             r_state <= w_state_next;
    end

    always_comb begin
        w_state_next   = r_state;
        out_gen_enable = 1'b0;
        out_gen_min    = r_min_hold;
        out_gen_max    = r_max_hold;
        case (r_state)
            S_IDLE:    if (in_start) w_state_next = in_mode ? S_IDX_REQ : S_VAL_REQ;
            S_IDX_REQ: begin
                out_gen_enable = 1'b1;
                out_gen_min    = '0;
                out_gen_max    = VAL_W'(NUM_VARS-1);
                w_state_next   = S_IDX_CAP;
            end
            S_IDX_CAP: w_state_next = S_VAL_REQ;
            S_VAL_REQ: begin
                out_gen_enable = w_legal;
                out_gen_min    = w_k_lo;
                out_gen_max    = w_k_hi;
                w_state_next   = S_VAL_CAP;
            end
            S_VAL_CAP: w_state_next = (!r_mode && !w_last_var) ? S_VAL_REQ : S_HOLD;
            S_HOLD:    if (in_ready) w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge in_clock) begin
        if (!in_reset_n) begin
            r_mode     <= 1'b0;
            r_k        <= '0;
            r_error    <= 1'b0;
            r_min_hold <= '0;
            r_max_hold <= '0;
            for (int i = 0; i < NUM_VARS; i++) begin
                r_lower[i] <= '0;
                r_upper[i] <= '0;
                r_prop[i]  <= '0;
            end
        end else begin
            r_min_hold <= out_gen_min;
            r_max_hold <= out_gen_max;
            if (w_accept) begin
                r_mode  <= in_mode;
                r_k     <= '0;
                r_error <= 1'b0;
                for (int i = 0; i < NUM_VARS; i++) begin
                    r_lower[i] <= in_lower[i*VAL_W +: VAL_W];
                    r_upper[i] <= in_upper[i*VAL_W +: VAL_W];
                    r_prop[i]  <= in_current[i*VAL_W +: VAL_W];
                end
            end
            if (r_state == S_IDX_CAP) begin
                r_k <= w_idx;
                if (!w_idx_ok) r_error <= 1'b1;
            end
            // Illegal ranges keep the slot's current value but still take their cycles.
            if (r_state == S_VAL_CAP) begin
                if (w_legal) r_prop[r_k] <= in_gen_random;
                else         r_error     <= 1'b1;
                if (!r_mode) r_k <= r_k + 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_VARS; gi++) begin : g_pack
            assign out_proposal[gi*VAL_W +: VAL_W] = r_prop[gi];
        end
    endgenerate

    assign out_valid = (r_state == S_HOLD);
    assign out_busy  = (r_state != S_IDLE);
    assign out_error = r_error;
endmodule
